// File: rtl/alu_exec_unit.sv
// EX-stage execution unit: single-cycle ALU ops plus an iterative shift-add multiplier.
// start/ready/valid handshake lets the pipeline stall while a multiply is in flight.
module alu_exec_unit #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = 5
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic [3:0]      ALU_control,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   output logic            ready,
   output logic            valid,
   output logic [XLEN-1:0] result,
   output logic            zero
);

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t               state_reg,  state_next;
   logic [XLEN-1:0]      result_reg, result_next;
   logic                 zero_reg,   zero_next;
   logic                 valid_reg,  valid_next;
   logic [XLEN-1:0]      acc_reg,    acc_next;
   logic [XLEN-1:0]      mcand_reg,  mcand_next;
   logic [XLEN-1:0]      mplr_reg,   mplr_next;
   logic [SHAMT_W-1:0]   cnt_reg,    cnt_next;

   logic [XLEN-1:0]      alu_out;
   logic [XLEN-1:0]      acc_step;
   logic [XLEN-1:0]      diff;
   logic                 ge_signed;

   assign diff      = src_a - src_b;
   assign ge_signed = ($signed(src_a) >= $signed(src_b));
   assign acc_step  = mplr_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

   // Unused codes (0, 8-15) deliberately produce 0 so the pipeline never waits on them.
   always_comb begin
      alu_out = '0;
      case (ALU_control)
         4'd2:    alu_out = src_a + src_b;
         4'd3:    alu_out = src_a << src_b[SHAMT_W-1:0];
         4'd4:    alu_out = src_a ^ src_b;
         4'd5:    alu_out = diff;
         4'd6:    alu_out = diff;
         4'd7:    alu_out = {{(XLEN-1){1'b0}}, ge_signed};
         default: alu_out = '0;
      endcase
   end

   always_comb begin
      state_next  = state_reg;
      result_next = result_reg;
      zero_next   = zero_reg;
      valid_next  = 1'b0;
      acc_next    = acc_reg;
      mcand_next  = mcand_reg;
      mplr_next   = mplr_reg;
      cnt_next    = cnt_reg;
      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               if (ALU_control == 4'd1) begin
                  state_next = MUL;
                  mcand_next = src_a;
                  mplr_next  = src_b;
                  acc_next   = '0;
                  cnt_next   = SHAMT_W'(XLEN - 1);
               end else begin
                  state_next  = DONE;
                  result_next = alu_out;
                  zero_next   = (alu_out == '0);
                  valid_next  = 1'b1;
               end
            end else begin
               state_next = IDLE;
            end
         end
         MUL: begin
            // The final iteration's partial product is folded straight into the result.
            acc_next   = acc_step;
            mcand_next = mcand_reg << 1;
            mplr_next  = mplr_reg >> 1;
            if (cnt_reg == '0) begin
               state_next  = DONE;
               result_next = acc_step;
               zero_next   = (acc_step == '0);
               valid_next  = 1'b1;
            end else begin
               cnt_next = cnt_reg - SHAMT_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg  <= IDLE;
         result_reg <= '0;
         zero_reg   <= 1'b0;
         valid_reg  <= 1'b0;
         acc_reg    <= '0;
         mcand_reg  <= '0;
         mplr_reg   <= '0;
         cnt_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         result_reg <= result_next;
         zero_reg   <= zero_next;
         valid_reg  <= valid_next;
         acc_reg    <= acc_next;
         mcand_reg  <= mcand_next;
         mplr_reg   <= mplr_next;
         cnt_reg    <= cnt_next;
      end
   end

   assign ready  = (state_reg != MUL);
   assign valid  = valid_reg;
   assign result = result_reg;
   assign zero   = zero_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected results queued at issue, compared on valid.
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  ALU_control = 4'd0;
   logic [31:0] src_a = '0;
   logic [31:0] src_b = '0;
   logic        ready;
   logic        valid;
   logic [31:0] result;
   logic        zero;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed {
      logic [31:0] r;
      logic        z;
   } exp_t;

   exp_t sb[$];

   alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .ALU_control(ALU_control),
      .src_a(src_a), .src_b(src_b), .ready(ready), .valid(valid),
      .result(result), .zero(zero)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      case (c)
         4'd1:    e.r = a * b;
         4'd2:    e.r = a + b;
         4'd3:    e.r = a << b[4:0];
         4'd4:    e.r = a ^ b;
         4'd5:    e.r = a - b;
         4'd6:    e.r = a - b;
         4'd7:    e.r = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
         default: e.r = 32'd0;
      endcase
      e.z = (e.r == 32'd0);
      return e;
   endfunction

   // Drives a start for the current cycle and queues its expected outcome.
   task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      ALU_control = c;
      src_a = a;
      src_b = b;
      sb.push_back(model(c, a, b));
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (valid !== 1'b0 || ready !== 1'b1 || result !== 32'd0 || zero !== 1'b0) begin
         n_err++;
         $display("FAIL reset: valid=%b ready=%b result=%h zero=%b, required 0 1 00000000 0",
                  valid, ready, result, zero);
      end else $display("txn reset: outputs at reset values");
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_add();
      exp_t e;
      @(negedge clk);
      issue(4'd2, 32'd5, 32'd7);
      @(negedge clk);
      start = 1'b0;
      e = sb.pop_front();
      n_cmp++;
      if (valid !== 1'b1 || result !== e.r || zero !== e.z || e.r !== 32'd12) begin
         n_err++;
         $display("FAIL add: valid=%b result=%h zero=%b, required 1 %h %b", valid, result, zero, e.r, e.z);
      end else $display("txn add: result=%h zero=%b", result, zero);
      @(negedge clk);
      n_cmp++;
      if (valid !== 1'b0 || result !== 32'd12) begin
         n_err++;
         $display("FAIL add_hold: valid=%b result=%h, required 0 0000000c", valid, result);
      end
   endtask

   // Table of single-cycle ops: sub, beq, bge both ways, sll with over-wide shift.
   task automatic test_single_ops();
      logic [3:0]  codes [5] = '{4'd6, 4'd5, 4'd7, 4'd7, 4'd3};
      logic [31:0] as    [5] = '{32'd3, 32'h1234, 32'hFFFFFFFF, 32'd1, 32'd1};
      logic [31:0] bs    [5] = '{32'd5, 32'h1234, 32'd1, 32'hFFFFFFFF, 32'h25};
      logic [31:0] req   [5] = '{32'hFFFFFFFE, 32'd0, 32'd0, 32'd1, 32'h20};
      exp_t e;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         issue(codes[i], as[i], bs[i]);
         @(negedge clk);
         start = 1'b0;
         e = sb.pop_front();
         n_cmp++;
         if (valid !== 1'b1 || result !== e.r || zero !== e.z || e.r !== req[i]) begin
            n_err++;
            $display("FAIL op%0d code=%0d: valid=%b result=%h zero=%b, required 1 %h %b",
                     i, codes[i], valid, result, zero, e.r, e.z);
         end else $display("txn code=%0d: result=%h zero=%b", codes[i], result, zero);
      end
   endtask

   task automatic test_mult();
      exp_t e;
      @(negedge clk);
      issue(4'd1, 32'hFFFFFFFF, 32'd3);
      for (int i = 1; i <= 32; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
         if (i == 5) begin
            start = 1'b1;
            ALU_control = 4'd2;
            src_a = 32'd100;
            src_b = 32'd1;
         end
         if (i == 6) start = 1'b0;
         n_cmp++;
         if (ready !== 1'b0 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL mul_busy cycle %0d: ready=%b valid=%b, required 0 0", i, ready, valid);
         end
      end
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if (valid !== 1'b1 || result !== e.r || zero !== e.z || e.r !== 32'hFFFFFFFD) begin
         n_err++;
         $display("FAIL mult: valid=%b result=%h zero=%b, required 1 %h %b", valid, result, zero, e.r, e.z);
      end else $display("txn mult: result=%h zero=%b", result, zero);
      @(negedge clk);
      n_cmp++;
      if (valid !== 1'b0 || ready !== 1'b1 || result !== 32'hFFFFFFFD) begin
         n_err++;
         $display("FAIL mult_after: valid=%b ready=%b result=%h, required 0 1 fffffffd", valid, ready, result);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic [3:0] codes [3] = '{4'd2, 4'd4, 4'd0};
      logic [31:0] as   [3] = '{32'd5, 32'hA5A5_0F0F, 32'd9};
      logic [31:0] bs   [3] = '{32'd7, 32'h0FF0_1234, 32'd9};
      @(negedge clk);
      issue(codes[0], as[0], bs[0]);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         e = sb.pop_front();
         n_cmp++;
         if (valid !== 1'b1 || result !== e.r || zero !== e.z) begin
            n_err++;
            $display("FAIL b2b%0d: valid=%b result=%h zero=%b, required 1 %h %b",
                     i, valid, result, zero, e.r, e.z);
         end else $display("txn b2b code=%0d: result=%h zero=%b", codes[i], result, zero);
         if (i < 2) issue(codes[i+1], as[i+1], bs[i+1]);
         else start = 1'b0;
      end
      @(negedge clk);
      n_cmp++;
      if (valid !== 1'b0 || zero !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_end: valid=%b zero=%b, required 0 1", valid, zero);
      end
   endtask

   task automatic test_reset_mid_mult();
      exp_t e;
      int lat;
      @(negedge clk);
      issue(4'd1, 32'd9, 32'd11);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      sb.delete();
      n_cmp++;
      if (valid !== 1'b0 || ready !== 1'b1 || result !== 32'd0 || zero !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset: valid=%b ready=%b result=%h zero=%b, required 0 1 00000000 0",
                  valid, ready, result, zero);
      end else $display("txn mid_reset: multiply aborted");
      repeat (2) begin
         @(negedge clk);
         n_cmp++;
         if (valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: valid=%b, required 0", valid);
         end
      end
      reset_n = 1'b1;
      @(negedge clk);
      issue(4'd1, 32'd6, 32'd7);
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (valid !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      e = sb.pop_front();
      n_cmp++;
      if (valid !== 1'b1 || lat != 33 || result !== e.r || e.r !== 32'd42 || zero !== e.z) begin
         n_err++;
         $display("FAIL mult_after_reset: valid=%b latency=%0d result=%h, required 1 33 %h",
                  valid, lat, result, e.r);
      end else $display("txn mult 6*7: result=%h latency=%0d", result, lat);
   endtask

   initial begin
      test_reset();
      test_add();
      test_single_ops();
      test_mult();
      test_back_to_back();
      test_reset_mid_mult();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
